// File: rtl/frame_update_scheduler.sv
// Frame update scheduler: on a chosen scanline, walks up to four clients in index order,
// pulsing each enabled client's start and waiting for its done strobe or a timeout.
module frame_update_scheduler #(
    parameter int V_TRIGGER = 480,
    parameter int TIMEOUT   = 1024
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       p_tick,
    input  logic [9:0] x,
    input  logic [9:0] y,
    input  logic       enable,
    input  logic [3:0] client_mask,
    input  logic [3:0] client_done,
    input  logic       err_clr,
    output logic [3:0] client_start,
    output logic       busy,
    output logic       frame_done,
    output logic [7:0] frame_count,
    output logic [3:0] err,
    output logic       overrun
);

    typedef enum logic [1:0] {IDLE, SELECT, WAIT, FINISH} state_t;

    localparam logic [9:0]  V_TRIG_L = 10'(V_TRIGGER);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  start_d;
    logic [3:0]  err_set;
    logic [1:0]  cidx;
    logic        trigger;

    assign cidx    = idx_q[1:0];
    assign trigger = p_tick && (x == 10'd0) && (y == V_TRIG_L);
    assign busy    = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        timer_d = timer_q;
        mask_d  = mask_q;
        start_d = '0;
        err_set = '0;
        case (state_q)
            IDLE: begin
                if (trigger && enable) begin
                    state_d = SELECT;
                    mask_d  = client_mask;
                    idx_d   = 3'd0;
                end
            end
            SELECT: begin
                if (idx_q[2]) begin
                    state_d = FINISH;
                end else if (!mask_q[cidx]) begin
                    idx_d = idx_q + 3'd1;
                end else begin
                    state_d = WAIT;
                    start_d = 4'b0001 << cidx;
                    timer_d = '0;
                end
            end
            WAIT: begin
                // done is checked first so a done on the final timeout clock still counts as done
                if (client_done[cidx]) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = SELECT;
                end else if (timer_q == TMO_LAST) begin
                    err_set = 4'b0001 << cidx;
                    idx_d   = idx_q + 3'd1;
                    state_d = SELECT;
                end else begin
                    timer_d = timer_q + 16'd1;
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            timer_q      <= '0;
            mask_q       <= '0;
            client_start <= '0;
            frame_done   <= 1'b0;
            frame_count  <= '0;
            err          <= '0;
            overrun      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            timer_q      <= timer_d;
            mask_q       <= mask_d;
            client_start <= start_d;
            frame_done   <= (state_d == FINISH);
            if (state_d == FINISH) begin
                frame_count <= frame_count + 8'd1;
            end
            // sticky flags: a new set in the same clock as err_clr survives the clear
            err     <= (err & ~{4{err_clr}}) | err_set;
            overrun <= (overrun && !err_clr) || (trigger && busy);
        end
    end

endmodule

// File: tb/tb_frame_update_scheduler.sv
// Randomized self-checking bench for frame_update_scheduler with an event-timeline reference model.
module tb_frame_update_scheduler;

    localparam int VT  = 480;
    localparam int TMO = 8;

    logic       clk = 1'b0;
    logic       reset;
    logic       p_tick;
    logic [9:0] x;
    logic [9:0] y;
    logic       enable;
    logic [3:0] client_mask;
    logic [3:0] client_done;
    logic       err_clr;
    logic [3:0] client_start;
    logic       busy;
    logic       frame_done;
    logic [7:0] frame_count;
    logic [3:0] err;
    logic       overrun;

    frame_update_scheduler #(.V_TRIGGER(VT), .TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset), .p_tick(p_tick), .x(x), .y(y), .enable(enable),
        .client_mask(client_mask), .client_done(client_done), .err_clr(err_clr),
        .client_start(client_start), .busy(busy), .frame_done(frame_done),
        .frame_count(frame_count), .err(err), .overrun(overrun)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // observed events, indexed by the number of rising edges seen so far
    int         st_cyc[$];
    logic [3:0] st_val[$];
    int         fd_cyc[$];

    // client behaviour: done arrives resp_d clocks after the start pulse (-1 = never)
    int         resp_d[4] = '{-1, -1, -1, -1};
    int         due[4];
    bit         pend[4];
    bit         noise_en = 0;
    logic [3:0] cur_mask = '0;

    always @(negedge clk) begin
        if (client_start != 4'b0) begin
            st_cyc.push_back(cyc);
            st_val.push_back(client_start);
        end
        if (frame_done) fd_cyc.push_back(cyc);
        for (int i = 0; i < 4; i++) begin
            if (client_start[i] && resp_d[i] >= 0) begin
                pend[i] = 1;
                due[i]  = cyc + resp_d[i];
            end
        end
        for (int i = 0; i < 4; i++) begin
            client_done[i] = (pend[i] && due[i] == cyc) ||
                             (noise_en && !cur_mask[i] && $urandom_range(0, 1) == 1);
            if (pend[i] && due[i] == cyc) pend[i] = 0;
        end
    end

    // reference expectations
    int         exp_st_c[$];
    logic [3:0] exp_st_v[$];
    int         exp_fd;
    logic [3:0] exp_err = '0;
    logic       exp_ovr = 0;
    logic [7:0] exp_fc  = '0;

    // Timeline of one sequence whose trigger is sampled at edge k: each skipped client costs
    // one clock, a served client costs its response time plus two, a timed-out one TMO+1.
    task automatic model_frame(input int k, input logic [3:0] m, output logic [3:0] new_err);
        int t;
        t = k + 1;
        new_err = '0;
        exp_st_c.delete();
        exp_st_v.delete();
        for (int i = 0; i < 4; i++) begin
            if (!m[i]) begin
                t = t + 1;
            end else begin
                exp_st_c.push_back(t);
                exp_st_v.push_back(4'b0001 << i);
                if (resp_d[i] >= 0 && resp_d[i] <= TMO - 1) begin
                    t = t + resp_d[i] + 2;
                end else begin
                    t = t + TMO + 1;
                    new_err[i] = 1'b1;
                end
            end
        end
        exp_fd = t;
    endtask

    task automatic drive_trig();
        p_tick = 1'b1;
        x      = 10'd0;
        y      = 10'(VT);
    endtask

    // near-miss patterns: each breaks exactly one of the three trigger conditions
    task automatic drive_idle();
        case ($urandom_range(0, 2))
            0: begin p_tick = 1'b1; x = 10'($urandom_range(1, 799)); y = 10'(VT); end
            1: begin p_tick = 1'b1; x = 10'd0; y = 10'(VT + 1 + $urandom_range(0, 40)); end
            default: begin p_tick = 1'b0; x = 10'd0; y = 10'(VT); end
        endcase
    endtask

    task automatic run_frame(input logic [3:0] m, input int retrig, input logic clr_with,
                             input logic [3:0] m_after, input logic en_after, input string tag);
        int k;
        logic [3:0] new_err;
        st_cyc.delete(); st_val.delete(); fd_cyc.delete();
        @(negedge clk);
        client_mask = m;
        cur_mask    = m;
        enable      = 1'b1;
        drive_trig();
        k = cyc + 1;
        model_frame(k, m, new_err);
        if (clr_with) exp_err = '0;
        exp_err = exp_err | new_err;
        exp_fc  = exp_fc + 8'd1;
        if (retrig != 0) exp_ovr = 1'b1;
        for (int n = 0; n < 400; n++) begin
            @(negedge clk);
            client_mask = m_after;
            enable      = en_after;
            if (retrig != 0 && cyc + 1 == k + retrig) begin
                drive_trig();
                err_clr = clr_with;
            end else begin
                drive_idle();
                err_clr = 1'b0;
            end
            if (cyc == k) begin
                checks++;
                if (busy !== 1'b1) begin
                    failures++;
                    $display("FAIL %s_busy_after_trigger got=%0b exp=1", tag, busy);
                end
            end
            if (fd_cyc.size() > 0 && cyc >= fd_cyc[0] + 1) break;
        end
        err_clr = 1'b0;
        enable  = 1'b1;
        checks++;
        if (st_cyc.size() !== exp_st_c.size()) begin
            failures++;
            $display("FAIL %s_start_count got=%0d exp=%0d", tag, st_cyc.size(), exp_st_c.size());
        end
        for (int i = 0; i < exp_st_c.size() && i < st_cyc.size(); i++) begin
            checks++;
            if (st_cyc[i] !== exp_st_c[i] || st_val[i] !== exp_st_v[i]) begin
                failures++;
                $display("FAIL %s_start%0d got=%b@%0d exp=%b@%0d", tag, i, st_val[i], st_cyc[i],
                         exp_st_v[i], exp_st_c[i]);
            end
        end
        checks++;
        if (fd_cyc.size() !== 1 || fd_cyc[0] !== exp_fd) begin
            failures++;
            $display("FAIL %s_frame_done got=%0d pulses first@%0d exp=1 pulse @%0d", tag,
                     fd_cyc.size(), (fd_cyc.size() > 0) ? fd_cyc[0] : -1, exp_fd);
        end
        checks++;
        if (err !== exp_err) begin
            failures++;
            $display("FAIL %s_err got=%b exp=%b", tag, err, exp_err);
        end
        checks++;
        if (overrun !== exp_ovr) begin
            failures++;
            $display("FAIL %s_overrun got=%b exp=%b", tag, overrun, exp_ovr);
        end
        checks++;
        if (frame_count !== exp_fc || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_count_idle got=%0d busy=%b exp=%0d busy=0", tag, frame_count, busy, exp_fc);
        end
    endtask

    task automatic do_err_clr(input string tag);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        exp_err = '0;
        exp_ovr = 1'b0;
        checks++;
        if (err !== 4'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL %s_err_clr got err=%b ovr=%b exp err=0000 ovr=0", tag, err, overrun);
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || client_start !== 4'b0 || frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got busy=%b start=%b fd=%b exp 0", busy, client_start, frame_done);
        end
        checks++;
        if (frame_count !== 8'd0 || err !== 4'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got fc=%0d err=%b ovr=%b exp 0", frame_count, err, overrun);
        end
        reset = 1'b1;
        exp_fc = '0; exp_err = '0; exp_ovr = 1'b0;
    endtask

    task automatic test_idle_patterns(input logic en, input logic give_trig, input string tag);
        int busy_hi;
        busy_hi = 0;
        st_cyc.delete();
        client_mask = 4'b1111;
        enable      = en;
        @(negedge clk);
        if (give_trig) drive_trig(); else drive_idle();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            drive_idle();
            if (busy) busy_hi++;
        end
        enable = 1'b1;
        checks++;
        if (busy_hi !== 0 || st_cyc.size() !== 0) begin
            failures++;
            $display("FAIL %s_stays_idle got busy_clocks=%0d starts=%0d exp 0", tag, busy_hi, st_cyc.size());
        end
        checks++;
        if (frame_count !== exp_fc) begin
            failures++;
            $display("FAIL %s_count got=%0d exp=%0d", tag, frame_count, exp_fc);
        end
    endtask

    task automatic test_reset_in_wait();
        int k;
        resp_d = '{-1, -1, -1, -1};
        st_cyc.delete(); st_val.delete();
        @(negedge clk);
        client_mask = 4'b0010;
        cur_mask    = 4'b0010;
        drive_trig();
        k = cyc + 1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive_idle();
            if (st_cyc.size() > 0) break;
        end
        checks++;
        if (st_cyc.size() !== 1 || st_cyc[0] !== k + 2) begin
            failures++;
            $display("FAIL rstwait_start got=%0d starts exp start@%0d", st_cyc.size(), k + 2);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL rstwait_busy_before got=%b exp=1", busy);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || client_start !== 4'b0 || frame_done !== 1'b0 || frame_count !== 8'd0 ||
            err !== 4'b0 || overrun !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_async got busy=%b fc=%0d err=%b ovr=%b exp all 0", busy, frame_count,
                     err, overrun);
        end
        @(negedge clk);
        reset = 1'b1;
        exp_fc = '0; exp_err = '0; exp_ovr = 1'b0;
        st_cyc.delete(); st_val.delete();
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            drive_idle();
        end
        checks++;
        if (st_cyc.size() !== 0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL rstwait_quiet got starts=%0d busy=%b exp 0", st_cyc.size(), busy);
        end
        resp_d = '{-1, 2, -1, -1};
        run_frame(4'b0010, 0, 1'b0, 4'b0010, 1'b1, "rstwait_fresh");
    endtask

    initial begin
        int total_fd;
        int total_st;
        logic [7:0] fc_before;
        reset = 1'b0; p_tick = 1'b0; x = '0; y = '0; enable = 1'b1;
        client_mask = '0; err_clr = 1'b0;

        test_reset();
        test_idle_patterns(1'b1, 1'b0, "near_miss");

        resp_d = '{3, 3, 3, 3};
        run_frame(4'b1111, 0, 1'b0, 4'b1111, 1'b1, "all_clients");

        resp_d = '{2, -1, -1, -1};
        run_frame(4'b0101, 0, 1'b0, 4'b0101, 1'b1, "timeout");

        do_err_clr("pre_ovr");
        resp_d = '{-1, -1, -1, -1};
        run_frame(4'b0001, 4, 1'b1, 4'b0001, 1'b1, "overrun");
        do_err_clr("post_ovr");

        test_idle_patterns(1'b0, 1'b1, "enable_off");
        resp_d = '{1, 0, 0, 0};
        run_frame(4'b0001, 0, 1'b0, 4'b1000, 1'b0, "mask_change");

        test_reset_in_wait();

        do_err_clr("pre_rand");
        noise_en = 1;
        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < 4; i++) resp_d[i] = int'($urandom_range(0, 11)) - 1;
            run_frame(4'($urandom), 0, 1'b0, 4'($urandom), 1'($urandom_range(0, 1)), "rand");
        end
        noise_en = 0;

        fc_before = frame_count;
        total_fd = 0;
        total_st = 0;
        for (int r = 0; r < 256; r++) begin
            run_frame(4'b0000, 0, 1'b0, 4'($urandom), 1'b1, "wrap");
            total_fd += fd_cyc.size();
            total_st += st_cyc.size();
        end
        checks++;
        if (total_fd !== 256 || total_st !== 0 || frame_count !== fc_before) begin
            failures++;
            $display("FAIL wrap_total got fd=%0d starts=%0d fc=%0d exp fd=256 starts=0 fc=%0d", total_fd,
                     total_st, frame_count, fc_before);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
